// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Parity generation and the PARITY state are compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  // state  | meaning
  // IDLE   | line high, waiting for Data_Valid
  // START  | start bit (low)
  // DATA   | data bits, LSB first
  // PARITY | parity bit (only with UART_TX_PARITY_EN)
  // STOP   | stop bit (high)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                  r_state;
  logic [PRESCALE_W-1:0]   r_pre_cnt;
  logic [IDX_W-1:0]        r_bit_idx;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [PRESCALE_W-1:0]   r_prescale;
  logic                    r_tx;
  logic                    r_busy;

  state_t                  w_state_nxt;
  logic [PRESCALE_W-1:0]   w_pre_cnt_nxt;
  logic [IDX_W-1:0]        w_bit_idx_nxt;
  logic                    w_tx_nxt;
  logic                    w_busy_nxt;
  logic                    w_accept;
  logic                    w_tc;
  logic [PRESCALE_W-1:0]   w_ps_eff;
  logic [PRESCALE_W-1:0]   w_ps_in_eff;
  logic [PRESCALE_W-1:0]   w_reload;

`ifdef UART_TX_PARITY_EN
  logic                    r_par_en;
  logic                    r_par_typ;
  logic                    w_parity;
  assign w_parity = (^r_data) ^ r_par_typ;
`else
  logic                    w_unused;
  assign w_unused = PAR_EN ^ PAR_TYP;
`endif

  // A prescale of zero would otherwise stall the bit timer, so it behaves as one.
  assign w_ps_eff    = (r_prescale == '0) ? PRESCALE_W'(1) : r_prescale;
  assign w_ps_in_eff = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
  assign w_reload    = w_ps_eff - PRESCALE_W'(1);
  assign w_tc        = (r_pre_cnt == '0);
  assign w_accept    = (r_state == IDLE) && Data_Valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_bit_idx_nxt = r_bit_idx;
    case (r_state)
      IDLE: begin
        if (Data_Valid) begin
          w_state_nxt   = START;
          w_pre_cnt_nxt = w_ps_in_eff - PRESCALE_W'(1);
        end
      end
      START: begin
        if (w_tc) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = '0;
          w_pre_cnt_nxt = w_reload;
        end else begin
          w_pre_cnt_nxt = r_pre_cnt - PRESCALE_W'(1);
        end
      end
      DATA: begin
        if (w_tc) begin
          w_pre_cnt_nxt = w_reload;
          if (r_bit_idx == LAST_IDX) begin
            w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = r_par_en ? PARITY : STOP;
`else
            w_state_nxt   = STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_pre_cnt_nxt = r_pre_cnt - PRESCALE_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tc) begin
          w_state_nxt   = STOP;
          w_pre_cnt_nxt = w_reload;
        end else begin
          w_pre_cnt_nxt = r_pre_cnt - PRESCALE_W'(1);
        end
      end
`endif
      STOP: begin
        if (w_tc) begin
          w_state_nxt   = IDLE;
          w_pre_cnt_nxt = '0;
        end else begin
          w_pre_cnt_nxt = r_pre_cnt - PRESCALE_W'(1);
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_pre_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line leads by no extra cycle.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b1;
    case (w_state_nxt)
      IDLE:   w_busy_nxt = 1'b0;
      START:  w_tx_nxt   = 1'b0;
      DATA:   w_tx_nxt   = r_data[w_bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
      PARITY: w_tx_nxt   = w_parity;
`endif
      STOP:   w_tx_nxt   = 1'b1;
      default: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_pre_cnt  <= '0;
      r_bit_idx  <= '0;
      r_data     <= '0;
      r_prescale <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      if (w_accept) begin
        r_data     <= P_DATA;
        r_prescale <= Prescale;
`ifdef UART_TX_PARITY_EN
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
`endif
      end
    end
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule
